// File: rtl/dmem_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the data-memory responder (slave).
// Carries the request fields plus the load-complete, busy and error handshakes.
interface dmem_responder_if;
    logic [1:0]  MemRW;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [1:0]  dsize;
    logic [31:0] drdata;
    logic        dready_n;
    logic        dbusy;
    logic        derr;

    modport master (
        output MemRW, daddr, dwdata, dsize,
        input  drdata, dready_n, dbusy, derr
    );

    modport slave (
        input  MemRW, daddr, dwdata, dsize,
        output drdata, dready_n, dbusy, derr
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency loads, posted stores through a write buffer.
// Latency: load strobes dready_n RD_LAT cycles after acceptance; stores accepted same cycle.
// Backpressure: dbusy (registered) holds stores when the buffer is full; loads wait for an empty buffer.
module dmem_responder #(
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 2,
    parameter int WB_DEPTH  = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   dbus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam logic [PW:0] WB_FULL = (PW+1)'(WB_DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    state_t          state;
    logic [3:0]      rd_cnt;
    logic [AW-1:0]   rd_idx;
    logic [1:0]      rd_lane;
    logic [1:0]      rd_size;
    logic            rd_err;

    logic [31:0]     mem [MEM_WORDS];

    logic [AW-1:0]   wb_idx [WB_DEPTH];
    logic [3:0]      wb_be  [WB_DEPTH];
    logic [31:0]     wb_dat [WB_DEPTH];
    logic [PW-1:0]   wb_wr_ptr, wb_rd_ptr;
    logic [PW:0]     wb_cnt, wb_cnt_nxt;
    logic [3:0]      drain_cnt;

    logic [AW-1:0]   idx;
    logic            misalign, acc_bad, rd_accept, st_try, st_push, st_err, pop;
    logic [3:0]      st_be;
    logic [31:0]     st_dat;
    logic            unused_addr_hi;

    assign idx            = dbus.daddr[AW+1:2];
    assign unused_addr_hi = ^dbus.daddr[31:AW+2];

    always_comb begin
        misalign  = ((dbus.dsize == 2'b01) && dbus.daddr[0]) ||
                    ((dbus.dsize == 2'b10) && (dbus.daddr[1:0] != 2'b00));
        acc_bad   = (dbus.MemRW == 2'b11) || (dbus.dsize == 2'b11) || misalign;
        rd_accept = (state == IDLE) && dbus.MemRW[1] && (wb_cnt == '0);
        st_try    = (dbus.MemRW == 2'b01) && !dbus.dbusy;
        st_push   = st_try && !acc_bad;
        st_err    = st_try && acc_bad;
        pop       = (wb_cnt != '0) && (drain_cnt == 4'(WR_LAT-1));
        wb_cnt_nxt = wb_cnt + (PW+1)'(st_push) - (PW+1)'(pop);
    end

    // Replicate store data across all lanes; byte-enables pick the target lane(s).
    always_comb begin
        st_be  = 4'b1111;
        st_dat = dbus.dwdata;
        case (dbus.dsize)
            2'b00: begin
                st_be  = 4'b0001 << dbus.daddr[1:0];
                st_dat = {4{dbus.dwdata[7:0]}};
            end
            2'b01: begin
                st_be  = dbus.daddr[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{dbus.dwdata[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] rd_fmt(logic [31:0] w, logic [1:0] lane,
                                           logic [1:0] size, logic err);
        logic [31:0] s;
        logic [31:0] r;
        s = w >> {lane, 3'b000};
        case (size)
            2'b00:   r = {24'b0, s[7:0]};
            2'b01:   r = {16'b0, s[15:0]};
            default: r = w;
        endcase
        if (err) r = '0;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            rd_idx        <= '0;
            rd_lane       <= '0;
            rd_size       <= '0;
            rd_err        <= 1'b0;
            dbus.dready_n <= 1'b1;
            dbus.drdata   <= '0;
            dbus.derr     <= 1'b0;
        end else begin
            dbus.derr <= st_err || (rd_accept && acc_bad);
            case (state)
                IDLE: begin
                    dbus.dready_n <= 1'b1;
                    dbus.drdata   <= '0;
                    if (rd_accept) begin
                        rd_idx  <= idx;
                        rd_lane <= dbus.daddr[1:0];
                        rd_size <= dbus.dsize;
                        rd_err  <= acc_bad;
                        if (RD_LAT == 1) begin
                            state         <= RD_DONE;
                            dbus.dready_n <= 1'b0;
                            dbus.drdata   <= rd_fmt(mem[idx], dbus.daddr[1:0], dbus.dsize, acc_bad);
                        end else begin
                            state  <= RD_WAIT;
                            rd_cnt <= 4'(RD_LAT-1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == 4'd1) begin
                        state         <= RD_DONE;
                        dbus.dready_n <= 1'b0;
                        dbus.drdata   <= rd_fmt(mem[rd_idx], rd_lane, rd_size, rd_err);
                    end else begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    dbus.dready_n <= 1'b1;
                    dbus.drdata   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wr_ptr  <= '0;
            wb_rd_ptr  <= '0;
            wb_cnt     <= '0;
            drain_cnt  <= '0;
            dbus.dbusy <= 1'b0;
        end else begin
            if (st_push) wb_wr_ptr <= wb_wr_ptr + PW'(1);
            if (pop)     wb_rd_ptr <= wb_rd_ptr + PW'(1);
            wb_cnt     <= wb_cnt_nxt;
            drain_cnt  <= ((wb_cnt == '0) || pop) ? 4'd0 : drain_cnt + 4'd1;
            dbus.dbusy <= (wb_cnt_nxt == WB_FULL);
        end
    end

    // Payload storage and the array carry no reset; only pointers/counters define validity.
    always_ff @(posedge clk) begin
        if (st_push) begin
            wb_idx[wb_wr_ptr] <= idx;
            wb_be[wb_wr_ptr]  <= st_be;
            wb_dat[wb_wr_ptr] <= st_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_be[wb_rd_ptr][b])
                    mem[wb_idx[wb_rd_ptr]][b*8 +: 8] <= wb_dat[wb_rd_ptr][b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads checked against a queue of expected data,
// plus handshake timing, error pulses, reset abandonment and address wrap.
module tb_dmem_responder;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;
    localparam int LIMIT  = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] sb [$];

    dmem_responder_if dbus ();

    dmem_responder #(
        .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .WB_DEPTH(2), .MEM_WORDS(1024)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dbus (dbus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        dbus.MemRW  = 2'b00;
        dbus.daddr  = '0;
        dbus.dwdata = '0;
        dbus.dsize  = 2'b10;
    endtask

    task automatic drain_wait();
        repeat (10) @(posedge clk);
    endtask

    task automatic do_store(string tag, logic [31:0] addr, logic [31:0] data,
                            logic [1:0] size, logic exp_err);
        int n;
        @(posedge clk); #1;
        dbus.MemRW = 2'b01; dbus.daddr = addr; dbus.dwdata = data; dbus.dsize = size;
        n = 0;
        @(negedge clk);
        while (dbus.dbusy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".accept"}, 32'(n < LIMIT), 32'd1);
        @(posedge clk); #1;
        dbus.MemRW = 2'b00;
        @(negedge clk);
        check({tag, ".derr"}, 32'(dbus.derr), 32'(exp_err));
    endtask

    task automatic do_load(string tag, logic [1:0] rw, logic [31:0] addr, logic [1:0] size,
                           logic [31:0] exp, logic exp_err, int exp_lat);
        int n;
        int errs;
        logic [31:0] e;
        sb.push_back(exp);
        @(posedge clk); #1;
        dbus.MemRW = rw; dbus.daddr = addr; dbus.dsize = size;
        n = 0;
        errs = 0;
        @(negedge clk);
        while (dbus.dready_n === 1'b1 && n < LIMIT) begin
            if (dbus.derr) errs++;
            @(negedge clk);
            n++;
        end
        if (dbus.derr) errs++;
        dbus.MemRW = 2'b00;
        check({tag, ".done"}, 32'(n < LIMIT), 32'd1);
        if (exp_lat >= 0) check({tag, ".lat"}, 32'(n), 32'(exp_lat));
        e = sb.pop_front();
        check({tag, ".data"}, dbus.drdata, e);
        check({tag, ".derr"}, 32'(errs), 32'(exp_err));
        @(negedge clk);
        check({tag, ".strobe1"}, 32'(dbus.dready_n), 32'd1);
    endtask

    initial begin
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.dready_n", 32'(dbus.dready_n), 32'd1);
        check("rst.dbusy",    32'(dbus.dbusy),    32'd0);
        check("rst.derr",     32'(dbus.derr),     32'd0);
        check("rst.drdata",   dbus.drdata,        32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Store then immediate load: load waits for the drain.
        do_store("st10", 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        check("st10.dbusy", 32'(dbus.dbusy), 32'd0);
        do_load("ld10", 2'b10, 32'h10, 2'b10, 32'hDEADBEEF, 1'b0, RD_LAT + 1);

        // Three back-to-back stores against a 2-entry buffer.
        drain_wait();
        @(posedge clk); #1;
        dbus.MemRW = 2'b01; dbus.dsize = 2'b10;
        dbus.daddr = 32'h40; dbus.dwdata = 32'hA0A0A0A0;
        @(negedge clk);
        check("b2b.busy0", 32'(dbus.dbusy), 32'd0);
        @(posedge clk); #1;
        dbus.daddr = 32'h44; dbus.dwdata = 32'hB1B1B1B1;
        @(negedge clk);
        check("b2b.busy1", 32'(dbus.dbusy), 32'd0);
        @(posedge clk); #1;
        dbus.daddr = 32'h48; dbus.dwdata = 32'hC2C2C2C2;
        @(negedge clk);
        check("b2b.full", 32'(dbus.dbusy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b.fall", 32'(dbus.dbusy), 32'd0);
        @(posedge clk); #1;
        bus_idle();
        do_load("b2b.r40", 2'b10, 32'h40, 2'b10, 32'hA0A0A0A0, 1'b0, -1);
        do_load("b2b.r44", 2'b10, 32'h44, 2'b10, 32'hB1B1B1B1, 1'b0, -1);
        do_load("b2b.r48", 2'b10, 32'h48, 2'b10, 32'hC2C2C2C2, 1'b0, -1);

        // Sub-word store merge and sub-word loads.
        do_store("st20", 32'h20, 32'h11223344, 2'b10, 1'b0);
        do_store("stb21", 32'h21, 32'h000000AA, 2'b00, 1'b0);
        drain_wait();
        do_load("ld20", 2'b10, 32'h20, 2'b10, 32'h1122AA44, 1'b0, RD_LAT);
        do_load("ldh22", 2'b10, 32'h22, 2'b01, 32'h00001122, 1'b0, RD_LAT);
        do_load("ldb21", 2'b10, 32'h21, 2'b00, 32'h000000AA, 1'b0, RD_LAT);

        // Error cases.
        do_load("ld13", 2'b10, 32'h13, 2'b10, 32'h0, 1'b1, RD_LAT);
        do_load("rw11", 2'b11, 32'h10, 2'b10, 32'h0, 1'b1, RD_LAT);
        do_load("rsvsz", 2'b10, 32'h10, 2'b11, 32'h0, 1'b1, RD_LAT);
        do_store("st04", 32'h04, 32'hCAFEF00D, 2'b10, 1'b0);
        do_store("sth05", 32'h05, 32'h00009999, 2'b01, 1'b1);
        do_load("ld04", 2'b10, 32'h04, 2'b10, 32'hCAFEF00D, 1'b0, -1);

        // Reset abandons an in-flight read and buffered stores.
        do_store("pre80", 32'h80, 32'h01010101, 2'b10, 1'b0);
        do_store("pre84", 32'h84, 32'h02020202, 2'b10, 1'b0);
        drain_wait();
        @(posedge clk); #1;
        dbus.MemRW = 2'b10; dbus.daddr = 32'h80; dbus.dsize = 2'b10;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        #1;
        check("rstrd.dready_n", 32'(dbus.dready_n), 32'd1);
        @(negedge clk);
        check("rstrd.nostrobe", 32'(dbus.dready_n), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        dbus.MemRW = 2'b01; dbus.dsize = 2'b10;
        dbus.daddr = 32'h80; dbus.dwdata = 32'h0000BAD0;
        @(posedge clk); #1;
        dbus.daddr = 32'h84; dbus.dwdata = 32'h0000BAD1;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("rstwb.full", 32'(dbus.dbusy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rstwb.dbusy", 32'(dbus.dbusy), 32'd0);
        check("rstwb.dready_n", 32'(dbus.dready_n), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        drain_wait();
        do_load("rst.r80", 2'b10, 32'h80, 2'b10, 32'h01010101, 1'b0, RD_LAT);
        do_load("rst.r84", 2'b10, 32'h84, 2'b10, 32'h02020202, 1'b0, RD_LAT);

        // Address wrap modulo MEM_WORDS*4.
        do_store("st1000", 32'h1000, 32'h00000055, 2'b10, 1'b0);
        do_load("wrap", 2'b10, 32'h0, 2'b10, 32'h00000055, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that answers the pipeline's MEM-stage load/store requests.
- Drives the `dready_n` and `dbusy` handshakes that the hazard/stall controller uses to freeze ID/EX/MEM.
- Reads are serviced after a fixed latency from an internal word array.
- Stores are posted into a small write buffer and drained to the array in the background.

Parameters:
- RD_LAT, 2, cycles from read acceptance to `dready_n` low (legal range 1..15).
- WR_LAT, 2, cycles to retire one write-buffer entry into the array (legal range 1..15).
- WB_DEPTH, 2, write-buffer entries (power of two, 2..8).
- MEM_WORDS, 1024, words in the backing array (power of two).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- MemRW  input  2  MEM-stage access type; bit1 = load, bit0 = store, held stable by the pipeline while stalled
- daddr  input  32  byte address
- dwdata  input  32  store data, right-aligned
- dsize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- drdata  output  32  load data, right-aligned, zero-extended; valid only while `dready_n`=0
- dready_n  output  1  active-low load-complete strobe
- dbusy  output  1  write buffer full; store not accepted this cycle
- derr  output  1  one-cycle pulse on misaligned, reserved-size or MemRW=11 access

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; `dready_n`=1, `dbusy`=0, `derr`=0, `drdata`=0.
  - Write buffer flushed (count=0, pointers 0); drain counter cleared.
  - Array contents are not reset.
- Reset asserted mid-read or mid-drain abandons the operation; pending buffered stores are lost.
- Array index = `daddr[1+log2(MEM_WORDS):2]`; higher address bits ignored, so addresses wrap modulo MEM_WORDS*4.
- Alignment rules:
  - Half access needs `daddr[0]`=0; word access needs `daddr[1:0]`=0.
  - Byte lane = `daddr[1:0]`; half lane = `daddr[1]`.
- Read FSM states IDLE, RD_WAIT, RD_DONE:
  - IDLE, MemRW[1]=1 and write buffer empty: capture the address, load counter with RD_LAT-1, go to RD_WAIT (RD_DONE directly if RD_LAT=1).
  - IDLE, MemRW[1]=1 and buffer non-empty: stay in IDLE, `dready_n`=1. Reads never bypass pending stores.
  - RD_WAIT: decrement counter; at 0 go to RD_DONE.
  - RD_DONE: `dready_n`=0 and `drdata` valid for exactly one cycle, then IDLE.
  - A read accepted in cycle T strobes `dready_n` in cycle T+RD_LAT.
  - MemRW[1] still high in the cycle after RD_DONE is a new request (the pipeline advanced).
- `dready_n`=1 in every state except RD_DONE.
- Store path:
  - Accept in any cycle with MemRW==01, `dbusy`=0 and legal alignment/size: push {index, byte-enables, lane-shifted data}.
  - Accepted in the same cycle, so the pipeline does not stall.
  - `dbusy` is registered: 1 exactly when count==WB_DEPTH after the update.
- Drain:
  - While the buffer is non-empty, count WR_LAT cycles, then write the head entry with byte-enables and pop.
  - Push and pop in the same cycle leave count unchanged.
  - Drain continues during reads in RD_WAIT.
- Error cases:
  - Misaligned, dsize=11, or MemRW=11: `derr` pulses 1 cycle.
  - A store in error is dropped (no push).
  - MemRW=11 is treated as a read.
  - A read in error completes normally with `drdata`=0.
- MemRW=00: no action; the drain proceeds.

Test Plan:
- After reset, store word 0xDEADBEEF at 0x10 (`dbusy`=0) then load 0x10 → `dready_n` stays high until the buffer drains; `dready_n`=0 with `drdata`=0xDEADBEEF exactly 1 + RD_LAT cycles after the read starts.
- Three back-to-back stores with WB_DEPTH=2, WR_LAT=2 → `dbusy`=1 in the cycle after the 2nd push; the 3rd store is held and accepted the cycle `dbusy` falls; all three words are readable afterwards.
- Store byte 0xAA at 0x21, then load word 0x20 (prior contents 0x11223344) → `drdata`=0x1122AA44. Load half 0x22 → 0x00001122.
- Load word at 0x13 → `derr` one-cycle pulse, `drdata`=0. Store half at 0x05 → `derr` pulse, array unchanged.
- Assert rst low during RD_WAIT with two stores buffered → `dready_n`=1 and `dbusy`=0 immediately; the buffered stores never reach the array.
- Address wrap with MEM_WORDS=1024: store 0x55 word at 0x1000, load 0x0000 → `drdata`=0x00000055.
